// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64 M-extension DIV/DIVU/REM/REMU and W forms.
// One quotient bit per cycle; the result is held until write-back takes it.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      rd_q, rd_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            rem_sel_q, rem_sel_d;
  logic            word_q, word_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return XLEN'(v);
  endfunction

  logic            signed_op, a_neg, b_neg, div_zero, ovf, fits;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, rem_dz;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] step_rem, step_quo, q_fin, r_fin, sel;

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    data_d    = data_q;
    rd_d      = rd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    rem_sel_d = rem_sel_q;
    word_d    = word_q;

    signed_op = ~in_op[0];
    a_ext     = in_word ? (signed_op ? sext32(in_rs1[31:0]) : zext32(in_rs1[31:0])) : in_rs1;
    b_ext     = in_word ? (signed_op ? sext32(in_rs2[31:0]) : zext32(in_rs2[31:0])) : in_rs2;
    a_neg     = signed_op & a_ext[XLEN-1];
    b_neg     = signed_op & b_ext[XLEN-1];
    a_abs     = a_neg ? -a_ext : a_ext;
    b_abs     = b_neg ? -b_ext : b_ext;
    div_zero  = (b_ext == '0);
    ovf       = signed_op & (in_word ? (in_rs1[31:0] == 32'h8000_0000 && in_rs2[31:0] == 32'hFFFF_FFFF)
                                     : (in_rs1 == MIN_NEG && in_rs2 == '1));
    rem_dz    = in_word ? sext32(in_rs1[31:0]) : in_rs1;

    // Restoring step: the shifted partial remainder needs one extra bit for the compare.
    trial     = {rem_q, quo_q[XLEN-1]};
    fits      = (trial >= {1'b0, dvs_q});
    step_rem  = trial[XLEN-1:0] - (fits ? dvs_q : '0);
    step_quo  = {quo_q[XLEN-2:0], fits};
    q_fin     = qneg_q ? -step_quo : step_quo;
    r_fin     = rneg_q ? -step_rem : step_rem;
    sel       = rem_sel_q ? r_fin : q_fin;

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          rd_d      = in_rd;
          word_d    = in_word;
          rem_sel_d = in_op[1];
          qneg_d    = a_neg ^ b_neg;
          rneg_d    = a_neg;
          cnt_d     = '0;
          if (div_zero) begin
            data_d  = in_op[1] ? rem_dz : '1;
            state_d = DONE;
          end else if (ovf) begin
            data_d  = in_op[1] ? '0 : a_ext;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          data_d  = word_q ? sext32(sel[31:0]) : sel;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only; datapath registers are reset too so out_data/out_rd read 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      rem_sel_q <= rem_sel_d;
      word_q    <= word_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_rd    = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference model + scoreboard compare process,
// directed vectors with literal expectations, and latency/hold/flush/reset checks.
module tb_div_unit;

  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            rstn, flush, in_valid, in_ready, in_word, out_valid, out_ready, busy;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_rs1, in_rs2, out_data;
  logic [4:0]      in_rd, out_rd;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] sa32, sb32, sr32;
    logic signed [63:0] sa64, sb64, sr64;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    sa32 = a32; sb32 = b32; sa64 = a; sb64 = b;
    r32 = '0;
    r64 = '0;
    if (w) begin
      if (b32 == 0) r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'h0 : a32;
      else begin
        case (op)
          2'b00: begin sr32 = sa32 / sb32; r32 = sr32; end
          2'b01: r32 = a32 / b32;
          2'b10: begin sr32 = sa32 % sb32; r32 = sr32; end
          default: r32 = a32 % b32;
        endcase
      end
      return {{32{r32[31]}}, r32};
    end
    if (b == 0) r64 = op[1] ? a : '1;
    else if (!op[0] && a == MIN64 && b == '1) r64 = op[1] ? 64'h0 : a;
    else begin
      case (op)
        2'b00: begin sr64 = sa64 / sb64; r64 = sr64; end
        2'b01: r64 = a / b;
        2'b10: begin sr64 = sa64 % sb64; r64 = sr64; end
        default: r64 = a % b;
      endcase
    end
    return r64;
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == MIN64 && b == '1));
    return (zero || ovf) ? 1 : XLEN + 1;
  endfunction

  // Scoreboard compare: every cycle a result is presented it must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_valid actual out_data=%h required=no result", out_data);
      end else begin
        check("sb_data", out_data, exp_q[0].data);
        check("sb_rd", {59'd0, out_rd}, {59'd0, exp_q[0].rd});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1 with in_ready high; returns at posedge+1 of cycle 1.
  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    exp_t e;
    // NOTE: inputs are driven with blocking assignments shortly after the edge, never at it.
    in_valid = 1'b1; in_op = op; in_word = w; in_rs1 = a; in_rs2 = b; in_rd = rd;
    e.data = ref_model(op, w, a, b);
    e.rd   = rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("in_ready_low_c1", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        output logic [63:0] got);
    issue(op, w, a, b, rd);
    wait_valid(name, ref_latency(op, w, a, b));
    got = out_data;
    @(posedge clk); #1;
    check({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=stuck required=finish");
    $fatal(1);
  end

  logic [63:0] got, d0;
  logic [4:0]  r0;
  int          vcount;

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_word = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with literal expectations.
    run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 5'd3, got);
    check("lit_divu_100_7", got, 64'd14);
    run_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2, 5'd4, got);
    check("lit_rem_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("div_m7_2", 2'b00, 1'b0, -64'sd7, 64'd2, 5'd5, got);
    check("lit_div_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_5_0", 2'b00, 1'b0, 64'd5, 64'd0, 5'd6, got);
    check("lit_div_5_0", got, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_5_0", 2'b11, 1'b0, 64'd5, 64'd0, 5'd7, got);
    check("lit_remu_5_0", got, 64'd5);
    run_op("div_ovf", 2'b00, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, got);
    check("lit_div_ovf", got, MIN64);
    run_op("rem_ovf", 2'b10, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, got);
    check("lit_rem_ovf", got, 64'd0);
    run_op("divw_min_1", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd10, got);
    check("lit_divw_min_1", got, 64'hFFFF_FFFF_8000_0000);
    run_op("divw_ovf", 2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd11, got);
    check("lit_divw_ovf", got, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_m100_7", 2'b10, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7, 5'd12, got);
    check("lit_remw_m100_7", got, 64'hFFFF_FFFF_FFFF_FFFE);

    // Model-only vectors.
    run_op("divuw_hi", 2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'hABCD_0000_0000_0003, 5'd13, got);
    run_op("remuw_z", 2'b11, 1'b1, 64'h0000_0001_8000_0001, 64'h5555_5555_0000_0000, 5'd14, got);
    run_op("div_max_m3", 2'b00, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd3, 5'd15, got);
    run_op("remu_big", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 5'd16, got);
    run_op("divu_max_1", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd17, got);
    run_op("rem_m100_m7", 2'b10, 1'b0, -64'sd100, -64'sd7, 5'd18, got);
    run_op("rd_zero", 2'b01, 1'b0, 64'd1000, 64'd10, 5'd0, got);
    check("lit_rd_zero", got, 64'd100);

    // Hold with out_ready low.
    out_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd12345, -64'sd17, 5'd21);
    wait_valid("hold", XLEN + 1);
    d0 = out_data;
    r0 = out_rd;
    repeat (10) begin @(posedge clk); #1; end
    check("hold_valid", {63'd0, out_valid}, 64'd1);
    check("hold_data", out_data, d0);
    check("hold_rd", {59'd0, out_rd}, {59'd0, r0});
    check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush in CALC cycle 20.
    issue(2'b01, 1'b0, 64'd999, 64'd3, 5'd22);
    repeat (19) begin @(posedge clk); #1; end
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_busy", {63'd0, busy}, 64'd0);
    vcount = 0;
    repeat (70) begin
      if (out_valid) vcount++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 64'(vcount), 64'd0);

    // Flush together with in_valid: nothing accepted.
    in_valid = 1'b1; flush = 1'b1; in_op = 2'b00; in_rs1 = 64'd8; in_rs2 = 64'd0; in_rd = 5'd23;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_accept_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset mid-CALC.
    issue(2'b00, 1'b0, 64'd77777, 64'd13, 5'd24);
    repeat (9) begin @(posedge clk); #1; end
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_out_data", out_data, 64'd0);
    check("arst_out_rd", {59'd0, out_rd}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset", 2'b00, 1'b0, 64'd77777, 64'd13, 5'd25, got);
    check("lit_post_reset", got, 64'd5982);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
